// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the raw bus, deframes 11-bit frames,
// and queues good scan codes in a FIFO exposed as two read-bus words.
module ps2_rx_fifo #(
  parameter int                     ADDRESS_WIDTH  = 14,
  parameter int                     DATA_WIDTH     = 64,
  parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDRESS   = 14'h2500,
  parameter logic [ADDRESS_WIDTH-1:0] STATUS_ADDRESS = 14'h2501,
  parameter int                     FIFO_DEPTH     = 8,
  parameter int                     SYNC_STAGES    = 2,
  parameter int                     TIMEOUT_CYCLES = 50000
) (
  input  logic                     system_clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic                     read_strobe,
  input  logic                     PS2_clk,
  input  logic                     PS2_data,
  output logic [DATA_WIDTH-1:0]    data,
  output logic                     irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic                   clk_prev_q;
  logic [1:0]             state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_ok_q, par_ok_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   push_pend_q, push_pend_d;
  logic [7:0]             push_byte_q, push_byte_d;
  logic [7:0]             err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [7:0]             mem_d [FIFO_DEPTH];

  logic sclk, sdat, fall, err_inc;
  logic data_hit, stat_hit, empty, full, pop, push, ovf_set, stat_clr;
  logic [DATA_WIDTH-1:0] rdata;

  assign sclk = clk_sync_q[SYNC_STAGES-1];
  assign sdat = dat_sync_q[SYNC_STAGES-1];
  assign fall = clk_prev_q & ~sclk;

  assign data_hit = (address == DATA_ADDRESS);
  assign stat_hit = (address == STATUS_ADDRESS);
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign pop      = read_strobe & data_hit & ~empty;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign push     = push_pend_q & (~full | pop);
  assign ovf_set  = push_pend_q & ~push;
  assign stat_clr = read_strobe & stat_hit;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], PS2_clk};
    dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], PS2_data};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    to_cnt_d    = '0;
    push_pend_d = 1'b0;
    push_byte_d = push_byte_q;
    err_inc     = 1'b0;

    if (state_q != S_IDLE && !fall) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_IDLE;
        err_inc = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end

    if (fall) begin
      case (state_q)
        S_IDLE: if (!sdat) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
          shift_d   = 8'd0;
        end
        S_DATA: begin
          shift_d   = {sdat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_ok_d = ((~^shift_q) == sdat);
          state_d  = S_STOP;
        end
        default: begin
          if (sdat && par_ok_q) begin
            push_pend_d = 1'b1;
            push_byte_d = shift_q;
          end else begin
            err_inc = 1'b1;
          end
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_byte_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    // A fresh event in the clearing cycle survives the clear.
    if (stat_clr)              err_d = {7'd0, err_inc};
    else if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
    else                       err_d = err_q;
    ovf_d = ovf_set | (ovf_q & ~stat_clr);
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      push_pend_q <= 1'b0;
      push_byte_q <= '0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_prev_q  <= sclk;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      to_cnt_q    <= to_cnt_d;
      push_pend_q <= push_pend_d;
      push_byte_q <= push_byte_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge system_clk) mem_q <= mem_d;

  always_comb begin
    rdata = '0;
    if (data_hit) begin
      rdata[7:0] = empty ? 8'd0 : mem_q[rd_ptr_q];
      rdata[8]   = ~empty;
    end else if (stat_hit) begin
      rdata[0]       = ~empty;
      rdata[1]       = full;
      rdata[2]       = ovf_q;
      rdata[8 +: CW] = count_q;
      rdata[23:16]   = err_q;
    end
  end

  assign data = (data_hit | stat_hit) ? rdata : {DATA_WIDTH{1'bz}};
  assign irq  = ~empty;

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Next-generation PS/2 keyboard receiver, clocked entirely on system_clk.
- Synchronises PS2_clk and PS2_data, then deframes 11-bit PS/2 frames on falling PS2_clk edges.
- Checks start, odd parity and stop bits, and has a mid-frame timeout watchdog.
- Queues good scan codes in a parametrised FIFO, readable through two memory-mapped words (data/pop and status) on the shared 64-bit read bus.

Parameters:
- ADDRESS_WIDTH, 14, width of address.
- DATA_WIDTH, 64, width of data bus; must be >= 32.
- DATA_ADDRESS, 14'h2500, word returning FIFO head; a read strobe here pops.
- STATUS_ADDRESS, 14'h2501, status/counter word; a read strobe here clears sticky flags.
- FIFO_DEPTH, 8, scan-code entries; power of two, 2..128.
- SYNC_STAGES, 2, synchroniser flops per PS/2 input; must be >= 2.
- TIMEOUT_CYCLES, 50000, system_clk cycles without a falling PS2_clk edge mid-frame before the frame is aborted.

Ports:
- system_clk, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous, active-low.
- address, input, ADDRESS_WIDTH, bus address.
- read_strobe, input, 1, one-cycle read qualifier; side effects occur only when high.
- PS2_clk, input, 1, raw PS/2 clock, asynchronous.
- PS2_data, input, 1, raw PS/2 data, asynchronous.
- data, output, DATA_WIDTH, read data; high-impedance unless address matches DATA_ADDRESS or STATUS_ADDRESS.
- irq, output, 1, high while the FIFO is non-empty.

Behaviour:
- Reset (reset=0, asynchronous), all of the following:
  - FIFO empty, pointers and count 0.
  - FSM in IDLE; bit counter 0; shift register 0.
  - Synchroniser flops preset to 1 (idle bus).
  - overflow=0; error_count=0; timeout counter 0; irq=0.
- Reset mid-frame discards the partial frame; no push occurs.
- Edge detect: fall = synced PS2_clk previous=1 and current=0; one-cycle pulse. The frame is sampled only on fall, using synced PS2_data.
- FSM, transitions on fall only:
  - IDLE: data=0 -> DATA with bit counter 0. Data=1 -> stay in IDLE; not an error.
  - DATA: shift bits in LSB first; after the 8th bit -> PARITY.
  - PARITY: compare against odd parity, i.e. the XOR of the 8 data bits, inverted, must equal the parity bit. Record mismatch -> STOP.
  - STOP: data=1 and parity ok -> push byte. Otherwise increment error_count, no push. -> IDLE in all cases.
- Timeout:
  - In any state other than IDLE, the counter increments each cycle and resets on fall.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, increment error_count, discard the frame.
- error_count: 8 bits, saturates at 255.
- Push is registered the cycle after the STOP fall. The byte is readable and irq rises on the following cycle.
- Full FIFO at push: byte dropped, overflow set sticky, FIFO unchanged.
- Same-cycle push and pop: pop of the head always occurs.
  - Push succeeds if not full, or if full with a simultaneous pop.
  - Count is unchanged when both succeed.
  - Pointers wrap modulo FIFO_DEPTH.
- Pop when empty: no effect.
- Read data, combinational from address and registered state:
  - DATA_ADDRESS:
    - data[7:0] = head byte (0 when empty).
    - data[8] = non-empty.
    - Remaining bits 0.
    - With read_strobe and non-empty, the head is popped at the clock edge.
  - STATUS_ADDRESS:
    - data[0] = non-empty.
    - data[1] = full.
    - data[2] = overflow.
    - data[15:8] = count, zero-extended.
    - data[23:16] = error_count.
    - Remaining bits 0.
    - With read_strobe: overflow and error_count clear at the edge. An error or overflow in the same cycle wins, giving error_count=1 or overflow=1.
  - Any other address: data = all z; read_strobe has no effect.
- irq = non-empty, registered-state driven, no glitches on reads of other addresses.

Test Plan:
- Reset release, then read DATA_ADDRESS and STATUS_ADDRESS -> data=0x0 and 0x0; irq=0; other address -> z.
- Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) at ~12 kHz PS2_clk -> irq=1 two cycles after the stop fall; DATA read = 0x11C; strobed read pops -> next DATA read = 0x0, irq=0.
- Frame 0x48 with parity bit 0 (should be 1) -> no push; STATUS[23:16]=1; strobed STATUS read -> error_count 0.
- FIFO_DEPTH=8: send 9 good frames 0x01..0x09 without reads -> STATUS = full=1, overflow=1, count=8; pops return 0x01..0x08 in order; 0x09 lost.
- Hold PS2_clk high after 4 data bits for TIMEOUT_CYCLES (override to 100) -> FSM returns to IDLE; error_count=1; next clean frame 0x5A received correctly.
- Full FIFO with strobed DATA read in the same cycle as a push -> pop and push both succeed; count stays 8; overflow stays 0.
- Assert reset mid-frame with 3 bytes queued -> immediate empty FIFO, irq=0; subsequent frame 0x29 received correctly.
